// File: rtl/reg_no_rst_en.sv
// Enable-gated data register without reset.
module reg_no_rst_en #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_rst_n_en.sv
// Enable-gated register with asynchronous active-low reset to a parameterised value.
module reg_rst_n_en #(
  parameter int unsigned      Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= ResetVal;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/root_5_en_multi_cycle.sv
// Multi-cycle integer fifth root: bitwise search, each candidate raised to the fifth power
// with one shared multiplier over four cycles, then compared against the argument.
module root_5_en_multi_cycle #(
  parameter int unsigned w = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  input  logic         arg_vld,
  input  logic [w-1:0] arg,
  output logic         arg_rdy,
  output logic         res_vld,
  output logic [w-1:0] res
);

  localparam int unsigned RW = (w + 4) / 5;
  localparam int unsigned PW = 5 * RW;
  localparam int unsigned BW = (RW > 1) ? $clog2(RW) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StCmp  = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] root_q, root_d, root_hit;
  logic [BW-1:0] bit_q, bit_d, bit_dec;
  logic [1:0]    mcnt_q, mcnt_d;
  logic [PW-1:0] prod_q, prod_d, cand, mul_out;
  logic [w-1:0]  arg_q, res_d;
  logic          arg_en, res_en, res_vld_d, hit;

  // PW bits hold any candidate^5 exactly, so the truncated product never wraps.
  assign cand     = PW'(root_q) | (PW'(1) << bit_q);
  assign mul_out  = prod_q * cand;
  assign hit      = (prod_q <= PW'(arg_q));
  assign root_hit = hit ? (root_q | (RW'(1) << bit_q)) : root_q;
  assign bit_dec  = bit_q - BW'(1);
  assign arg_rdy  = (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    root_d    = root_q;
    bit_d     = bit_q;
    mcnt_d    = mcnt_q;
    prod_d    = prod_q;
    arg_en    = 1'b0;
    res_en    = 1'b0;
    res_d     = res;
    res_vld_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arg_vld) begin
          arg_en  = 1'b1;
          root_d  = '0;
          bit_d   = BW'(RW - 1);
          prod_d  = PW'(1) << (RW - 1);
          mcnt_d  = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        prod_d = mul_out;
        mcnt_d = mcnt_q + 2'd1;
        if (mcnt_q == 2'd3) begin
          state_d = StCmp;
        end
      end
      StCmp: begin
        root_d = root_hit;
        if (bit_q == '0) begin
          res_en    = 1'b1;
          res_d     = w'(root_hit);
          res_vld_d = 1'b1;
          state_d   = StDone;
        end else begin
          bit_d   = bit_dec;
          prod_d  = PW'(root_hit) | (PW'(1) << bit_dec);
          mcnt_d  = '0;
          state_d = StMul;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      root_q  <= '0;
      bit_q   <= '0;
      mcnt_q  <= '0;
      prod_q  <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      root_q  <= root_d;
      bit_q   <= bit_d;
      mcnt_q  <= mcnt_d;
      prod_q  <= prod_d;
    end
  end

  reg_rst_n_en #(
    .Width   (1),
    .ResetVal(1'b0)
  ) u_res_vld (
    .clk_i (clk),
    .rst_ni(rst_n),
    .en_i  (clk_en),
    .d_i   (res_vld_d),
    .q_o   (res_vld)
  );

  reg_rst_n_en #(
    .Width   (w),
    .ResetVal('0)
  ) u_res (
    .clk_i (clk),
    .rst_ni(rst_n),
    .en_i  (clk_en & res_en),
    .d_i   (res_d),
    .q_o   (res)
  );

  reg_no_rst_en #(
    .Width(w)
  ) u_arg (
    .clk_i(clk),
    .en_i (clk_en & arg_en),
    .d_i  (arg),
    .q_o  (arg_q)
  );

endmodule

// File: tb/tb_root_5_en_multi_cycle.sv
// Randomised self-checking bench for the fifth-root block at w=8 and w=16.
module tb_root_5_en_multi_cycle;

  logic        clk = 1'b0;
  logic        rst_n, clk_en;
  logic        vld8, vld16, rdy8, rdy16, rv8, rv16;
  logic [7:0]  arg8, res8;
  logic [15:0] arg16, res16;
  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  root_5_en_multi_cycle #(.w(8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .arg_vld(vld8),
    .arg    (arg8),
    .arg_rdy(rdy8),
    .res_vld(rv8),
    .res    (res8)
  );

  root_5_en_multi_cycle #(.w(16)) u_dut16 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .arg_vld(vld16),
    .arg    (arg16),
    .arg_rdy(rdy16),
    .res_vld(rv16),
    .res    (res16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Largest x with x**5 <= y, by plain search.
  function automatic int unsigned ref_root5(input int unsigned y);
    longint unsigned x = 0;
    while ((x + 1) ** 5 <= longint'(y)) x++;
    return int'(x);
  endfunction

  function automatic logic get_rdy(input bit big);
    return big ? rdy16 : rdy8;
  endfunction

  function automatic logic get_rv(input bit big);
    return big ? rv16 : rv8;
  endfunction

  function automatic logic [31:0] get_res(input bit big);
    return big ? 32'(res16) : 32'(res8);
  endfunction

  task automatic set_in(input bit big, input logic v, input int unsigned a);
    if (big) begin
      vld16 = v;
      arg16 = a[15:0];
    end else begin
      vld8 = v;
      arg8 = a[7:0];
    end
  endtask

  // mode 0: clk_en always 1; 1: toggling 0,1,...; 2: random. junk: poke arg while busy.
  task automatic run_op(input bit big, input int unsigned a, input int mode, input bit junk);
    int unsigned lat  = big ? 20 : 10;
    int unsigned n    = 0;
    bit          seen = 0;
    bit          early_rdy = 0;
    int unsigned exp  = ref_root5(a);
    logic [31:0] held;
    @(negedge clk);
    clk_en = 1'b1;
    check("rdy_idle", 32'(get_rdy(big)), 32'd1);
    set_in(big, 1'b1, a);
    @(posedge clk);
    #1;
    check("rdy_busy", 32'(get_rdy(big)), 32'd0);
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      case (mode)
        0:       clk_en = 1'b1;
        1:       clk_en = (c % 2 == 1);
        default: clk_en = 1'($urandom_range(0, 1));
      endcase
      if (junk) set_in(big, 1'b1, $urandom);
      else      set_in(big, 1'b0, 0);
      @(posedge clk);
      if (clk_en) n++;
      #1;
      if (get_rv(big)) seen = 1;
      else if (get_rdy(big)) early_rdy = 1;
    end
    check("vld_seen", 32'(seen), 32'd1);
    check("rdy_low_busy", 32'(early_rdy), 32'd0);
    check("latency", n, lat);
    check("result", get_res(big), exp);
    held = get_res(big);
    // Disabled cycle: everything holds.
    @(negedge clk);
    clk_en = 1'b0;
    @(posedge clk);
    #1;
    check("vld_hold", 32'(get_rv(big)), 32'd1);
    check("rdy_hold", 32'(get_rdy(big)), 32'd0);
    // Leaving DONE with arg_vld possibly high must not start a new operation.
    @(negedge clk);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    check("vld_drop", 32'(get_rv(big)), 32'd0);
    check("rdy_back", 32'(get_rdy(big)), 32'd1);
    check("res_held", get_res(big), held);
    @(negedge clk);
    set_in(big, 1'b0, 0);
  endtask

  initial begin
    bit          any_rv;
    int unsigned dirs8[6]  = '{243, 242, 0, 31, 32, 255};
    int unsigned dirs16[3] = '{65535, 59049, 59048};
    rst_n  = 1'b0;
    clk_en = 1'b0;
    vld8   = 1'b0;
    vld16  = 1'b0;
    arg8   = '0;
    arg16  = '0;
    #2;
    check("rst_rdy8", 32'(rdy8), 32'd1);
    check("rst_rv8", 32'(rv8), 32'd0);
    check("rst_res8", 32'(res8), 32'd0);
    check("rst_rdy16", 32'(rdy16), 32'd1);
    check("rst_res16", 32'(res16), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (dirs8[i]) run_op(1'b0, dirs8[i], 0, 1'b0);
    foreach (dirs16[i]) run_op(1'b1, dirs16[i], 0, 1'b0);
    run_op(1'b0, 100, 1, 1'b0);
    run_op(1'b0, 243, 0, 1'b1);

    // Reset part way through an operation.
    @(negedge clk);
    clk_en = 1'b1;
    set_in(1'b0, 1'b1, 243);
    @(posedge clk);
    #1;
    set_in(1'b0, 1'b0, 0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rdy", 32'(rdy8), 32'd1);
    check("midrst_rv", 32'(rv8), 32'd0);
    check("midrst_res", 32'(res8), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    any_rv = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (rv8) any_rv = 1;
    end
    check("no_pulse_after_rst", 32'(any_rv), 32'd0);
    run_op(1'b0, 32, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      bit big = 1'($urandom_range(0, 1));
      int unsigned a = big ? $urandom_range(0, 65535) : $urandom_range(0, 255);
      run_op(big, a, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/root_5_en_multi_cycle.md
ROOT_5_EN_MULTI_CYCLE -- requirements
Module: root_5_en_multi_cycle

Interface
REQ-001 Parameter: w, 8, operand/result width in bits.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 clk_en  input  1  clock enable; all state advances only on clk edges with clk_en=1.
REQ-005 arg_vld  input  1  argument valid.
REQ-006 arg  input  w  unsigned argument y.
REQ-007 arg_rdy  output  1  block idle, can accept an argument.
REQ-008 res_vld  output  1  result valid.
REQ-009 res  output  w  floor of the fifth root of y, zero-extended.

Function
REQ-010 Result SHALL be the largest unsigned x with x^5 <= y, computed without truncation (inverse of the 5th-power block).
REQ-011 Localparams: RW = (w+4)/5 result bits searched; PW = 5*RW product width; all powers SHALL be computed in PW bits, never wrapping.
REQ-012 States: IDLE, MUL, CMP, DONE; arg_rdy=1 only in IDLE.
REQ-013 IDLE: enabled edge with arg_vld=1 -> latch arg, root=0, bit=RW-1, cand=root|(1<<bit), prod=cand, mcnt=0, go MUL.
REQ-014 MUL: each enabled edge prod=prod*cand, mcnt++; after 4th multiply go CMP.
REQ-015 CMP: if prod <= latched arg then root|=1<<bit; if bit==0 go DONE, else bit--, reload cand/prod/mcnt, go MUL.
REQ-016 DONE: res_vld=1 and res=final root (registered); next enabled edge -> IDLE, res_vld=0.
REQ-017 Latency: res_vld rises exactly 5*RW enabled edges after the accepting edge (w=8: 10) and stays high for exactly one enabled cycle.
REQ-018 res SHALL hold its last value until the next result; it updates only on the DONE-entering edge.
REQ-019 arg_vld while busy (MUL/CMP/DONE) SHALL be ignored; no queuing; arg changes while busy SHALL NOT affect the result.
REQ-020 clk_en=0: all registers, including res_vld and arg_rdy, hold unchanged regardless of inputs.
REQ-021 Back-to-back: an argument offered with arg_vld=1 on the edge leaving DONE is not accepted; acceptance requires IDLE.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, arg_rdy=1, res_vld=0, res=0, root/prod/bit/mcnt=0, independent of clk and clk_en.
REQ-023 Reset mid-computation SHALL abandon the operation; no res_vld pulse for it after release.
REQ-024 Latched argument register needs no reset value.

Structure
REQ-025 No shared package; RW, PW and state encodings are localparams of this module.
REQ-026 Control flags (res_vld) SHALL use the existing reg_rst_n_en sub-module; data registers without reset may use reg_no_rst_en.
REQ-027 One multiplier of PW bits shared across all MUL cycles; no unrolled fifth-power logic.

Verification
REQ-028 w=8, clk_en=1, arg=243 accepted -> after 10 edges res_vld=1 one cycle, res=3; arg=242 -> res=2.
REQ-029 w=8: arg=0 -> 0; arg=31 -> 1; arg=32 -> 2; arg=255 -> 3.
REQ-030 w=16: arg=65535 -> 9; arg=59049 -> 9; arg=59048 -> 8; res_vld after 20 edges.
REQ-031 w=8, arg=100, clk_en toggling 1,0,1,0... -> res_vld after 10 enabled edges (20 clk), held high through disabled cycles, res=2.
REQ-032 arg=243 accepted, then arg_vld=1 arg=0 during busy -> res=3, only one res_vld pulse; arg_rdy=0 until return to IDLE.
REQ-033 rst_n pulsed low at edge 5 of a computation -> outputs reset at once, no res_vld afterwards; new arg=32 afterwards -> res=2.
